pa_f_spsram_512x38_ctrl: RTL
============================

PA_F_SPSRAM_512X38_CTRL -- requirements
Module: pa_f_spsram_512x38_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 9, SRAM word address width (depth 2^ADDR_WIDTH).
REQ-002 Parameter DATA_WIDTH, default 38, SRAM word width.
REQ-003 Parameter INIT_VALUE, default 0, word written to every entry during initialisation.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of CLK.
REQ-005 CLK  input  1  clock, shared with the SRAM macro.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 init_req  input  1  single-cycle pulse requesting re-initialisation of the whole array.
REQ-008 init_done  output  1  high when initialisation is complete and requests are accepted.
REQ-009 req_vld  input  1  request valid.
REQ-010 req_rdy  output  1  request ready; a request transfers on req_vld & req_rdy.
REQ-011 req_wr  input  1  1 = write, 0 = read.
REQ-012 req_addr  input  ADDR_WIDTH  word address.
REQ-013 req_wdata  input  DATA_WIDTH  write data.
REQ-014 req_wmask  input  DATA_WIDTH  per-bit write enable, active high.
REQ-015 rsp_vld  output  1  read data valid.
REQ-016 rsp_rdy  input  1  read data accepted.
REQ-017 rsp_rdata  output  DATA_WIDTH  read data.
REQ-018 A / CEN / D / GWEN / WEN  outputs  ADDR_WIDTH / 1 / DATA_WIDTH / 1 / DATA_WIDTH  SRAM port drives; CEN, GWEN and WEN are active low, WEN per bit.
REQ-019 Q  input  DATA_WIDTH  SRAM read data; valid the cycle after a CEN=0 read; held while CEN=1.

Function
REQ-020 FSM states SHALL be INIT, IDLE and DRAIN.
REQ-021 INIT: a 9-bit counter SHALL sweep addresses 0..2^ADDR_WIDTH-1, one per cycle, driving CEN=0, GWEN=0, WEN=all 0, D=INIT_VALUE, A=counter.
REQ-022 INIT -> IDLE SHALL occur after the write to the last address; init_done SHALL go high the cycle after that write, i.e. exactly 2^ADDR_WIDTH cycles after leaving INIT entry.
REQ-023 In INIT and DRAIN, req_rdy SHALL be 0.
REQ-024 In IDLE, req_rdy SHALL equal (~rsp_vld | rsp_rdy) & ~init_req.
REQ-025 An accepted write SHALL drive CEN=0, GWEN=0, A=req_addr, D=req_wdata, WEN=~req_wmask in the same cycle, and SHALL produce no response.
REQ-026 An accepted write with req_wmask all 0 SHALL still drive CEN=0 with WEN all 1, leaving memory unchanged.
REQ-027 An accepted read SHALL drive CEN=0, GWEN=1, WEN=all 1, A=req_addr; rsp_vld SHALL rise the following cycle.
REQ-028 rsp_rdata SHALL be Q, unregistered; read latency SHALL be 1 cycle.
REQ-029 rsp_vld SHALL clear on rsp_vld & rsp_rdy unless a new read is accepted in the same cycle, in which case it SHALL stay 1; back-to-back reads SHALL sustain one per cycle.
REQ-030 When no request is accepted, CEN SHALL be 1, GWEN 1 and WEN all 1; A and D are don't-care. Q therefore holds a stalled response.
REQ-031 A read after a write to the same address in the next cycle SHALL return the newly written data.
REQ-032 init_req in IDLE with rsp_vld=0 SHALL enter INIT next cycle; with rsp_vld=1 SHALL enter DRAIN and latch the request.
REQ-033 DRAIN -> INIT SHALL occur in the cycle after rsp_vld & rsp_rdy; no new request is accepted in DRAIN.
REQ-034 init_done SHALL drop the cycle INIT is entered; init_req in INIT or DRAIN SHALL be ignored.
REQ-035 Simultaneous init_req and req_vld in IDLE: the request SHALL NOT be accepted; init_req wins.

Reset
REQ-036 RST=1 SHALL force state INIT, counter 0, init_done 0, rsp_vld 0, req_rdy 0 and the init latch cleared; sweep starts at address 0 the cycle after RST falls.
REQ-037 RST asserted mid-INIT, mid-DRAIN or with a pending response SHALL discard all progress and restart the sweep from address 0; the pending response is lost.

Verification
REQ-038 Reset, hold rsp_rdy=1 -> CEN=0 for 512 consecutive cycles on A=0..511 with D=0, then init_done=1; reading addresses 0, 255 and 511 returns 0.
REQ-039 Write 0x3F_FFFF_FFFF mask all-1 to addr 5, then read addr 5 in the next cycle -> rsp_vld one cycle later, rsp_rdata=0x3F_FFFF_FFFF.
REQ-040 Write 0x15_5555_5555 to addr 7 with mask 0x00_0000_FFFF over prior 0 -> read returns 0x00_0000_5555.
REQ-041 Stream reads to addr 1,2,3 with rsp_rdy low for 3 cycles on the second response -> req_rdy=0 and CEN=1 while stalled, rsp_rdata stable, then all three responses delivered in order with none lost.
REQ-042 init_req while a response is stalled -> DRAIN; after rsp_rdy, the full 512-cycle sweep runs, init_done returns, and a prior written address reads INIT_VALUE.
REQ-043 RST pulse at sweep address 100 -> sweep restarts at 0 and init_done rises 512 cycles after RST falls.

Source files
------------

// File: rtl/pa_f_spsram_512x38_ctrl.sv
// Single-port SRAM controller: sweeps the array to INIT_VALUE after reset or on request,
// then serves one read or write per cycle with a 1-cycle read latency and response backpressure.
module pa_f_spsram_512x38_ctrl #(
  parameter int                    ADDR_WIDTH = 9,
  parameter int                    DATA_WIDTH = 38,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  input  logic [DATA_WIDTH-1:0] Q
);

  // DRAIN is itself the latched init request: it is only reachable through init_req.
  typedef enum logic [1:0] {INIT, IDLE, DRAIN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  rsp_vld_q;
  logic                  cnt_last;
  logic                  acc;
  logic                  rd_acc;

  assign cnt_last  = (cnt == {ADDR_WIDTH{1'b1}});
  assign req_rdy   = ~RST & (state == IDLE) & (~rsp_vld_q | rsp_rdy) & ~init_req;
  assign acc       = req_vld & req_rdy;
  assign rd_acc    = acc & ~req_wr;
  assign init_done = ~RST & (state != INIT);
  assign rsp_vld   = rsp_vld_q;
  // Q holds while CEN=1, so a stalled response stays stable without a local copy.
  assign rsp_rdata = Q;

  always_ff @(posedge CLK) begin
    if (RST) state <= INIT;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      rsp_vld_q <= 1'b0;
    end else begin
      cnt       <= (state == INIT) ? cnt + 1'b1 : '0;
      rsp_vld_q <= rd_acc | (rsp_vld_q & ~rsp_rdy);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt_last) state_nxt = IDLE;
      IDLE:    if (init_req) state_nxt = rsp_vld_q ? DRAIN : INIT;
      // Also leave if the response was consumed in the same cycle init_req arrived.
      DRAIN:   if (~rsp_vld_q | rsp_rdy) state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = req_addr;
    D    = req_wdata;
    if (~RST && state == INIT) begin
      CEN  = 1'b0;
      GWEN = 1'b0;
      WEN  = '0;
      A    = cnt;
      D    = INIT_VALUE;
    end else if (acc) begin
      CEN  = 1'b0;
      GWEN = ~req_wr;
      WEN  = req_wr ? ~req_wmask : '1;
    end
  end

endmodule
